pt_write_port: RTL and testbench
================================

# pt_write_port

Memory-side write responder for the projective transform's pixel output stream. Accepts pixel writes (pt_pixel_write, pt_x, pt_y, pt_wr) under the ptflag ready handshake and buffers them in a small FIFO. Issues them as pipelined ZBT SRAM writes whenever the display read path leaves a free slot. Sits between projective_transform and the ZBT arbiter inside memory_interface.

## Interface
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- LINE_PIXELS, 640: pixels per line; used as the address stride.
- LINES, 480: lines per frame; used by the bounds check.
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pt_pixel_write  input  18  pixel data from the transform
- pt_x  input  10  destination column
- pt_y  input  9  destination line
- pt_wr  input  1  write request; a write is accepted on any edge where pt_wr=1 and ptflag=1
- ptflag  output  1  ready to accept a write (registered)
- mem_busy  input  1  display read owns the ZBT slot this cycle
- mem_addr  output  19  ZBT word address
- mem_we  output  1  ZBT write strobe, one cycle per word
- mem_wdata  output  36  write data, aligned to the ZBT pipeline
- mem_wdata_oe  output  1  data bus drive enable
- writes_dropped  output  16  saturating count of rejected out-of-range writes (only when PT_WRITE_BOUNDS_CHECK_EN is defined)

## Operation
- Accept:
  - On an accepted write, compute addr = (pt_y<<9) + (pt_y<<7) + pt_x, which equals pt_y*640 + pt_x, truncated to 19 bits.
  - Push {addr, pixel}, 37 bits, into the FIFO.
- Ready:
  - ptflag is registered high when the free slots after this edge's push/pop are at least 2.
  - This guarantees room for one write already in flight from a writer that sampled ptflag the previous cycle.
- Issue:
  - On each edge where the FIFO is non-empty and mem_busy=0, pop the head.
  - Register mem_addr = entry addr and mem_we = 1.
  - Otherwise mem_we = 0 and mem_addr holds its value.
- Data pipeline:
  - A 2-stage shift register carries the popped pixel.
  - mem_wdata = {18'b0, pixel} and mem_wdata_oe = 1 are asserted exactly 2 cycles after the matching mem_we.
  - mem_wdata_oe is low in all other cycles.
- FIFO control:
  - Read/write pointers are log2(DEPTH)+1 bits wide; the extra bit distinguishes full from empty.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
- Simultaneous push and pop: the count is unchanged, and pointers wrap modulo DEPTH.
- Push to a full FIFO is a protocol violation. The write is discarded and no pointer or counter changes.
- mem_busy asserted continuously: the FIFO fills, ptflag falls, and no data is lost.
- Reset (including mid-burst):
  - Pointers are cleared and the FIFO is emptied.
  - The data pipeline is flushed: mem_wdata_oe=0 on the next cycle, even if writes were in flight.
  - Pending writes are lost.
- Reset values of outputs:
  - ptflag=1, mem_we=0, mem_addr=0, mem_wdata=0, mem_wdata_oe=0, writes_dropped=0.
  - ptflag=1 after reset is required; it follows from the empty FIFO.

## Timing
- Accepted at edge N, FIFO was empty, mem_busy=0 at N+1: mem_we=1 during cycle N+1→N+2, and mem_wdata_oe=1 two cycles later.
- Sustained throughput: one write per cycle while mem_busy=0.
- ptflag falls on the edge where the occupancy reaches DEPTH-1.
- ptflag rises on the edge where the occupancy returns to DEPTH-2 or less.

## Configuration
- PT_WRITE_BOUNDS_CHECK_EN defined:
  - Writes with pt_x ≥ LINE_PIXELS or pt_y ≥ LINES are accepted by the handshake but not pushed.
  - writes_dropped increments and saturates at 16'hFFFF.
- PT_WRITE_BOUNDS_CHECK_EN undefined:
  - All accepted writes are pushed, with addresses truncated to 19 bits.
  - The writes_dropped port is absent.

## Test plan
- Single write: after reset, pt_x=5, pt_y=2, pixel=18'h2A5A with mem_busy=0 → next cycle mem_we=1, mem_addr=1285; two cycles later mem_wdata=36'h000002A5A with mem_wdata_oe=1.
- Burst under stall: hold mem_busy=1 and write every cycle pt_wr honours ptflag → ptflag falls at occupancy 7 (DEPTH=8). Release mem_busy → 8 consecutive mem_we with addresses in push order, then ptflag=1.
- Simultaneous push/pop: at occupancy 3, push and pop on the same edge for 20 cycles → occupancy stays 3 and pointers wrap cleanly past DEPTH.
- Bounds (macro defined): pt_x=640, pt_y=0 → no mem_we and writes_dropped=1. Then pt_x=639, pt_y=479 → mem_addr=307199.
- Reset mid-operation: assert reset with 4 entries queued and 2 data stages in flight → next cycle mem_we=0, mem_wdata_oe=0, ptflag=1; no stale writes afterward.

Source files
------------

// File: rtl/pt_write_port_if.sv
// Pixel-write and ZBT-write signal bundle for pt_write_port.
// writes_dropped exists only when PT_WRITE_BOUNDS_CHECK_EN is defined.
interface pt_write_port_if;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr;
  logic        ptflag;
  logic        mem_busy;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [35:0] mem_wdata;
  logic        mem_wdata_oe;
`ifdef PT_WRITE_BOUNDS_CHECK_EN
  logic [15:0] writes_dropped;

  modport slave (
    input  pt_pixel_write, pt_x, pt_y, pt_wr, mem_busy,
    output ptflag, mem_addr, mem_we, mem_wdata, mem_wdata_oe, writes_dropped
  );
  modport master (
    output pt_pixel_write, pt_x, pt_y, pt_wr, mem_busy,
    input  ptflag, mem_addr, mem_we, mem_wdata, mem_wdata_oe, writes_dropped
  );
`else
  modport slave (
    input  pt_pixel_write, pt_x, pt_y, pt_wr, mem_busy,
    output ptflag, mem_addr, mem_we, mem_wdata, mem_wdata_oe
  );
  modport master (
    output pt_pixel_write, pt_x, pt_y, pt_wr, mem_busy,
    input  ptflag, mem_addr, mem_we, mem_wdata, mem_wdata_oe
  );
`endif
endinterface

// File: rtl/pt_write_port.sv
// FIFO-buffered ZBT write responder: mem_we 1 cycle after a push into an empty FIFO, data 2 cycles after mem_we.
// Backpressure via registered ptflag with a 2-slot margin; PT_WRITE_BOUNDS_CHECK_EN enables range drop + counter.
module pt_write_port #(
  parameter int DEPTH       = 8,
  parameter int LINE_PIXELS = 640,
  parameter int LINES       = 480
) (
  input  logic            clk,
  input  logic            reset,
  pt_write_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || LINE_PIXELS < 1 || LINES < 1) begin : g_cfg_err
    $error("pt_write_port: DEPTH must be a power of two >= 4 and geometry positive");
  end

  logic [AW:0]   r_wptr, r_rptr;
  logic [36:0]   r_mem [DEPTH];
  logic          r_ptflag;
  logic          r_we;
  logic [18:0]   r_addr;
  logic [17:0]   r_pix;
  logic          r_s1_vld, r_s2_vld;
  logic [17:0]   r_s1_pix, r_s2_pix;

  logic          w_accept, w_in_range, w_push, w_pop, w_full, w_empty;
  logic [18:0]   w_addr;
  logic [AW:0]   w_cnt, w_cnt_nxt;
  logic [36:0]   w_head;

  assign w_accept  = bus.pt_wr & r_ptflag;
  assign w_addr    = 19'(32'(bus.pt_y) * LINE_PIXELS + 32'(bus.pt_x));
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_push    = w_accept & w_in_range & ~w_full;
  assign w_pop     = ~w_empty & ~bus.mem_busy;
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign w_cnt     = r_wptr - r_rptr;
  assign w_cnt_nxt = w_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

`ifdef PT_WRITE_BOUNDS_CHECK_EN
  logic [15:0] r_dropped;

  assign w_in_range = (32'(bus.pt_x) < LINE_PIXELS) && (32'(bus.pt_y) < LINES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropped <= 16'd0;
    end else if (w_accept && !w_in_range && r_dropped != 16'hFFFF) begin
      r_dropped <= r_dropped + 16'd1;
    end
  end

  assign bus.writes_dropped = r_dropped;
`else
  assign w_in_range = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {w_addr, bus.pt_pixel_write};
    end
  end

  // Ready keeps one slot spare for a write launched against last cycle's ptflag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ptflag <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_pix    <= '0;
      r_s1_vld <= 1'b0;
      r_s1_pix <= '0;
      r_s2_vld <= 1'b0;
      r_s2_pix <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= w_head[36:18];
        r_pix  <= w_head[17:0];
      end
      r_ptflag <= (w_cnt_nxt <= (AW+1)'(DEPTH - 2));
      r_we     <= w_pop;
      r_s1_vld <= r_we;
      r_s1_pix <= r_pix;
      r_s2_vld <= r_s1_vld;
      r_s2_pix <= r_s1_pix;
    end
  end

  assign bus.ptflag       = r_ptflag;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = {18'b0, r_s2_pix};
  assign bus.mem_wdata_oe = r_s2_vld;

endmodule

// File: tb/tb_pt_write_port.sv
// Directed bench for pt_write_port: queue-based reference model checked every cycle plus literal spot checks.
module tb_pt_write_port;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pt_write_port_if bus();

  pt_write_port #(.DEPTH(DEPTH), .LINE_PIXELS(640), .LINES(480)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of pending {addr,pixel}, outputs derived from edge history.
  logic [36:0] q[$];
  bit          m_valid = 0;
  bit          m_ptflag = 1;
  bit          m_we = 0;
  logic [18:0] m_addr = '0;
  bit          h_vld [3];
  logic [17:0] h_pix [3];
  int          m_dropped = 0;

  always @(posedge clk) begin : model
    logic [36:0] head;
    bit          acc, pop, push, inr;
    int          pre_size;
    logic [18:0] a;
    m_valid = 1;
    if (reset) begin
      q.delete();
      m_ptflag  = 1;
      m_we      = 0;
      m_addr    = '0;
      m_dropped = 0;
      for (int i = 0; i < 3; i++) begin
        h_vld[i] = 0;
        h_pix[i] = '0;
      end
    end else begin
      acc      = bus.pt_wr && m_ptflag;
      a        = 19'(int'(bus.pt_y) * 640 + int'(bus.pt_x));
      inr      = 1;
`ifdef PT_WRITE_BOUNDS_CHECK_EN
      inr = (int'(bus.pt_x) < 640) && (int'(bus.pt_y) < 480);
      if (acc && !inr && m_dropped < 65535) m_dropped++;
`endif
      pre_size = q.size();
      pop      = (pre_size > 0) && !bus.mem_busy;
      push     = acc && inr && (pre_size < DEPTH);
      h_vld[2] = h_vld[1]; h_pix[2] = h_pix[1];
      h_vld[1] = h_vld[0]; h_pix[1] = h_pix[0];
      h_vld[0] = pop;
      if (pop) begin
        head     = q.pop_front();
        m_addr   = head[36:18];
        h_pix[0] = head[17:0];
      end
      m_we = pop;
      if (push) q.push_back({a, bus.pt_pixel_write});
      m_ptflag = (DEPTH - q.size()) >= 2;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ptflag", bus.ptflag, m_ptflag);
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata_oe", bus.mem_wdata_oe, h_vld[2]);
      if (h_vld[2]) chk("mem_wdata", bus.mem_wdata, {18'b0, h_pix[2]});
`ifdef PT_WRITE_BOUNDS_CHECK_EN
      chk("writes_dropped", bus.writes_dropped, m_dropped);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit wr, input logic [9:0] x, input logic [8:0] y, input logic [17:0] pix);
    bus.pt_wr          = wr;
    bus.pt_x           = x;
    bus.pt_y           = y;
    bus.pt_pixel_write = pix;
  endtask

  initial begin
    int nwe;
    drive(0, '0, '0, '0);
    bus.mem_busy = 0;
    reset = 1;
    repeat (3) tick();
    chk("rst_ptflag", bus.ptflag, 1);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_oe", bus.mem_wdata_oe, 0);
    reset = 0;
    tick();

    // Single write
    drive(1, 10'd5, 9'd2, 18'h2A5A);
    tick();
    drive(0, '0, '0, '0);
    tick();
    chk("t1_we", bus.mem_we, 1);
    chk("t1_addr", bus.mem_addr, 1285);
    tick();
    chk("t1_oe_early", bus.mem_wdata_oe, 0);
    tick();
    chk("t1_oe", bus.mem_wdata_oe, 1);
    chk("t1_wdata", bus.mem_wdata, 36'h000002A5A);
    repeat (2) tick();

    // Burst under stall: seven accepted, then one more once ptflag recovers
    bus.mem_busy = 1;
    for (int i = 0; i < 12; i++) begin
      drive(1, 10'(10 + i), 9'd3, 18'(18'h100 + i));
      tick();
      if (i == 5) chk("burst_ptflag_occ6", bus.ptflag, 1);
      if (i == 6) chk("burst_ptflag_occ7", bus.ptflag, 0);
    end
    chk("burst_no_we", bus.mem_we, 0);
    bus.mem_busy = 0;
    drive(1, 10'd100, 9'd4, 18'h3FF00);
    nwe = 0;
    tick();
    nwe += int'(bus.mem_we);
    chk("burst_first_addr", bus.mem_addr, 1930);
    tick();
    nwe += int'(bus.mem_we);
    drive(0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      nwe += int'(bus.mem_we);
      if (i == 5) chk("burst_8th_addr", bus.mem_addr, 2660);
    end
    chk("burst_we_count", nwe, 8);
    chk("burst_ptflag_end", bus.ptflag, 1);

    // Simultaneous push/pop at occupancy 3
    bus.mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 10'(200 + i), 9'd7, 18'(18'h2000 + i));
      tick();
    end
    bus.mem_busy = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 10'(300 + i), 9'd8, 18'(18'h3000 + i));
      tick();
      chk("pp_we", bus.mem_we, 1);
    end
    chk("pp_ptflag", bus.ptflag, 1);
    drive(0, '0, '0, '0);
    repeat (6) tick();

    // Reset with 4 queued and 2 in flight
    bus.mem_busy = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 10'(400 + i), 9'd9, 18'(18'h1000 + i));
      tick();
    end
    drive(0, '0, '0, '0);
    bus.mem_busy = 0;
    repeat (2) tick();
    reset = 1;
    tick();
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_oe", bus.mem_wdata_oe, 0);
    chk("mid_rst_ptflag", bus.ptflag, 1);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stale_we", bus.mem_we, 0);
      chk("stale_oe", bus.mem_wdata_oe, 0);
    end

    // Out-of-range handling
    drive(1, 10'd640, 9'd0, 18'h15555);
    tick();
    drive(0, '0, '0, '0);
`ifdef PT_WRITE_BOUNDS_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("oob_no_we", bus.mem_we, 0);
    end
    chk("oob_dropped", bus.writes_dropped, 1);
`else
    tick();
    chk("oob_we", bus.mem_we, 1);
    chk("oob_addr", bus.mem_addr, 640);
    repeat (2) tick();
`endif
    drive(1, 10'd639, 9'd479, 18'h0ABCD);
    tick();
    drive(0, '0, '0, '0);
    tick();
    chk("corner_we", bus.mem_we, 1);
    chk("corner_addr", bus.mem_addr, 307199);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
